// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
//   REG_FIELD_W : width of a register field (file select + 4-bit index)
//   NREGS       : registers per file
//   CNT_W       : width of each per-register pending-write counter
//   reg_field_t : {is_vec, idx}; is_vec selects the vector file
//   reg_flat()  : maps a register field to a flat index 0..31
//                 (scalar 0..15, vector 16..31)
package id_sb_pkg;

    localparam int unsigned REG_FIELD_W = 5;
    localparam int unsigned NREGS       = 16;
    localparam int unsigned CNT_W       = 2;

    typedef struct packed {
        logic       is_vec;
        logic [3:0] idx;
    } reg_field_t;

    function automatic logic [REG_FIELD_W-1:0] reg_flat(reg_field_t f);
        return {f.is_vec, f.idx};
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Decode <-> scoreboard signal bundle.
//   issue_*      : instruction presented by decode (valid, flush, we, rd, rs1/rs2 + use flags)
//   wb_en/vwb_en : scalar / vector writeback enables, wb_addr is the shared index
//   stall/accept : hazard decision for the current issue
//   pend_*       : per-register "write in flight" flags
//   sb_empty     : nothing in flight; sb_err: sticky under/overflow
// Modports: master = decode/writeback side, slave = scoreboard.
interface id_hazard_scoreboard_if;

    logic        issue_valid;
    logic        issue_flush;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        wb_en;
    logic        vwb_en;
    logic [3:0]  wb_addr;
    logic        stall;
    logic        accept;
    logic [15:0] pend_scalar;
    logic [15:0] pend_vector;
    logic        sb_empty;
    logic        sb_err;

    modport master (
        output issue_valid, issue_flush, issue_we, issue_rd,
               use_rs1, use_rs2, issue_rs1, issue_rs2,
               wb_en, vwb_en, wb_addr,
        input  stall, accept, pend_scalar, pend_vector, sb_empty, sb_err
    );

    modport slave (
        input  issue_valid, issue_flush, issue_we, issue_rd,
               use_rs1, use_rs2, issue_rs1, issue_rs2,
               wb_en, vwb_en, wb_addr,
        output stall, accept, pend_scalar, pend_vector, sb_empty, sb_err
    );

endinterface

// File: rtl/id_hazard_scoreboard_sb_counter.sv
// One pending-write counter: up/down, saturating at both ends.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : issue / retire of a write to this register
//   cnt        : current count of in-flight writes
//   err        : combinational pulse when this cycle's update would
//                underflow (dec at 0) or overflow (inc at max)
module sb_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);

    logic up, down, at_zero, at_max;

    assign up      = inc & ~dec;
    assign down    = dec & ~inc;
    assign at_zero = (cnt == '0);
    assign at_max  = (cnt == '1);
    assign err     = (up & at_max) | (down & at_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (up && !at_max) begin
            cnt <= cnt + 1'b1;
        end else if (down && !at_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage scoreboard: counts in-flight writes to 16 scalar and 16
// vector registers and stalls decode on RAW or counter-full hazards.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_hazard_scoreboard_if slave (issue, writeback, status)
// Hazards look only at registered counters, so a writeback in cycle N
// clears the stall in N+1, not N.
module id_hazard_scoreboard
    import id_sb_pkg::*;
#(
    parameter int unsigned NREGS = id_sb_pkg::NREGS,
    parameter int unsigned CNT_W = id_sb_pkg::CNT_W
) (
    input logic                   clk,
    input logic                   rst_n,
    id_hazard_scoreboard_if.slave bus
);

    localparam int unsigned NCNT = 2 * NREGS;

    logic [CNT_W-1:0]       cnt [NCNT];
    logic [NCNT-1:0]        err_vec;
    logic [REG_FIELD_W-1:0] rs1_flat, rs2_flat, rd_flat;
    logic                   raw1, raw2, full, live, stall_int, accept_int;
    logic                   err_q;

    assign rs1_flat = reg_flat(reg_field_t'(bus.issue_rs1));
    assign rs2_flat = reg_flat(reg_field_t'(bus.issue_rs2));
    assign rd_flat  = reg_flat(reg_field_t'(bus.issue_rd));

    always_comb begin
        raw1       = bus.use_rs1  & (cnt[rs1_flat] != '0);
        raw2       = bus.use_rs2  & (cnt[rs2_flat] != '0);
        full       = bus.issue_we & (cnt[rd_flat] == '1);
        live       = bus.issue_valid & ~bus.issue_flush;
        stall_int  = live & (raw1 | raw2 | full);
        accept_int = live & ~stall_int;
    end

    // Scalar register 0 is hardwired: no counter, never pending, never errors.
    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        if (g == 0) begin : g_zero
            assign cnt[g]     = '0;
            assign err_vec[g] = 1'b0;
        end else begin : g_trk
            logic inc, dec;
            assign inc = accept_int & bus.issue_we & (rd_flat == REG_FIELD_W'(g));
            if (g < NREGS) begin : g_s
                assign dec = bus.wb_en & (bus.wb_addr == 4'(g));
            end else begin : g_v
                assign dec = bus.vwb_en & (bus.wb_addr == 4'(g - NREGS));
            end
            sb_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc),
                .dec   (dec),
                .cnt   (cnt[g]),
                .err   (err_vec[g])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|err_vec) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.pend_scalar = '0;
        bus.pend_vector = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            bus.pend_scalar[i] = (cnt[i] != '0);
            bus.pend_vector[i] = (cnt[NREGS + i] != '0);
        end
    end

    assign bus.sb_empty = ~(|bus.pend_scalar | |bus.pend_vector);
    assign bus.sb_err   = err_q;
    assign bus.stall    = stall_int;
    assign bus.accept   = accept_int;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: directed scenarios plus
// randomized traffic, all compared against a counter-array reference model.
module tb_id_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if bus ();

    id_hazard_scoreboard #(.NREGS(16), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: flat array of pending-write counts, index = {is_vec, idx}.
    int m_cnt [32];
    bit m_err;
    localparam int MAXC = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input bit fl, input bit we, input logic [4:0] rd,
                          input bit u1, input logic [4:0] rs1, input bit u2, input logic [4:0] rs2,
                          input bit wb, input bit vwb, input logic [3:0] addr);
        bus.issue_valid = v;   bus.issue_flush = fl; bus.issue_we = we; bus.issue_rd = rd;
        bus.use_rs1 = u1;      bus.issue_rs1 = rs1;  bus.use_rs2 = u2;  bus.issue_rs2 = rs2;
        bus.wb_en = wb;        bus.vwb_en = vwb;     bus.wb_addr = addr;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0);
    endtask

    function automatic bit exp_stall();
        bit haz;
        haz = (bus.use_rs1 && m_cnt[bus.issue_rs1] != 0) ||
              (bus.use_rs2 && m_cnt[bus.issue_rs2] != 0) ||
              (bus.issue_we && m_cnt[bus.issue_rd] == MAXC);
        return bus.issue_valid && !bus.issue_flush && haz;
    endfunction

    function automatic bit exp_accept();
        return bus.issue_valid && !bus.issue_flush && !exp_stall();
    endfunction

    task automatic check_outputs(input string ph);
        logic [15:0] ps, pv;
        for (int i = 0; i < 16; i++) begin
            ps[i] = (m_cnt[i] != 0);
            pv[i] = (m_cnt[16+i] != 0);
        end
        check({ph, ".stall"},       32'(bus.stall),       32'(exp_stall()));
        check({ph, ".accept"},      32'(bus.accept),      32'(exp_accept()));
        check({ph, ".pend_scalar"}, 32'(bus.pend_scalar), 32'(ps));
        check({ph, ".pend_vector"}, 32'(bus.pend_vector), 32'(pv));
        check({ph, ".sb_empty"},    32'(bus.sb_empty),    32'(ps == 0 && pv == 0));
        check({ph, ".sb_err"},      32'(bus.sb_err),      32'(m_err));
    endtask

    // Check at the falling edge, then apply the cycle's effect to the model.
    task automatic step(input string ph);
        bit acc;
        @(negedge clk);
        check_outputs(ph);
        acc = exp_accept();
        for (int j = 1; j < 32; j++) begin
            bit inc, dec;
            inc = acc && bus.issue_we && (int'(bus.issue_rd) == j);
            dec = (j < 16) ? (bus.wb_en  && int'(bus.wb_addr) == j)
                           : (bus.vwb_en && int'(bus.wb_addr) == j - 16);
            if (inc && !dec) begin
                if (m_cnt[j] == MAXC) m_err = 1; else m_cnt[j]++;
            end else if (dec && !inc) begin
                if (m_cnt[j] == 0) m_err = 1; else m_cnt[j]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [3:0] pool [6];
        pool = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd9, 4'd15};
        return {1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)]};
    endfunction

    initial begin
        model_reset();
        idle();
        #1;
        check_outputs("async_reset0");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle");

        // Scalar RAW on r3, cleared only the cycle after writeback.
        set_in(1, 0, 1, 5'h03, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); step("issue_r3");
        check("pend_r3", 32'(bus.pend_scalar), 32'h0008);
        set_in(1, 0, 0, 5'd0, 1, 5'h03, 0, 5'd0, 0, 0, 4'd0); step("raw_r3_a");
        step("raw_r3_b");
        set_in(1, 0, 0, 5'd0, 1, 5'h03, 0, 5'd0, 1, 0, 4'd3);
        @(negedge clk); check("stall_in_wb_cycle", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        m_cnt[3] = 0;
        set_in(1, 0, 0, 5'd0, 1, 5'h03, 0, 5'd0, 0, 0, 4'd0); step("raw_r3_clear");

        // Vector write does not block a scalar read of the same index.
        set_in(1, 0, 1, 5'h13, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); step("issue_v3");
        check("pend_v3", 32'(bus.pend_vector), 32'h0008);
        check("pend_s_zero", 32'(bus.pend_scalar), 32'h0000);
        set_in(1, 0, 0, 5'd0, 1, 5'h03, 0, 5'd0, 0, 0, 4'd0); step("s3_read");
        set_in(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 4'd3); step("v3_wb");

        // Counter-full stall on r7, then simultaneous issue + writeback.
        repeat (3) begin
            set_in(1, 0, 1, 5'h07, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); step("fill_r7");
        end
        check("full_stall", 32'(bus.stall), 32'd1);
        step("full_r7");
        set_in(1, 0, 1, 5'h07, 0, 5'd0, 0, 5'd0, 1, 0, 4'd7); step("full_wb_r7");
        set_in(1, 0, 1, 5'h07, 0, 5'd0, 0, 5'd0, 1, 0, 4'd7); step("both_r7");
        set_in(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 4'd7); step("drain_r7_a");
        step("drain_r7_b");

        // r0 is never tracked; flush blocks acceptance even with a hazard.
        set_in(1, 0, 1, 5'h00, 0, 5'd0, 1, 5'h00, 0, 0, 4'd0); step("r0_issue");
        check("r0_not_pending", 32'(bus.pend_scalar), 32'h0000);
        set_in(1, 0, 1, 5'h05, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); step("issue_r5");
        set_in(1, 1, 1, 5'h05, 1, 5'h05, 0, 5'd0, 0, 0, 4'd0); step("flush_haz");
        set_in(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 4'd5); step("wb_r5");

        // Underflow on r9 is sticky.
        set_in(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 4'd9); step("underflow_r9");
        idle();
        repeat (3) step("err_sticky");

        // Asynchronous reset mid-operation, between clock edges.
        set_in(1, 0, 1, 5'h1A, 0, 5'd0, 0, 5'd0, 0, 0, 4'd0); step("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_reset");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                   pick_reg(), $urandom_range(0, 1) == 1, pick_reg(),
                   $urandom_range(0, 1) == 1, pick_reg(),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   4'($urandom_range(0, 15) & 4'hB));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
